ccip_mmio_csr: RTL and testbench
================================

Name: ccip_mmio_csr

Overview:
- MMIO register responder sitting directly downstream of the AFU top-level CCI-P ports.
- Consumes MMIO read/write requests unpacked from the CCI-P Rx port.
- Returns read responses for the AFU's Tx channel-2 port.
- Implements the AFU device feature header (DFH), AFU UUID, a scratch register, a free-running cycle counter and a write counter.

Parameters:
- AFU_ID, 128'h0, AFU UUID returned at AFU_ID_L/AFU_ID_H (top level drives it from the JSON-generated UUID).
- DFH_FEATURE_ID, 12'h000, DFH[11:0] feature id.
- DFH_VERSION, 4'h0, DFH[15:12] version.

Ports:
- pClk  in  1  primary CCI-P clock; all logic on rising edge.
- pck_cp2af_softReset  in  1  synchronous, active-high reset.
- rx_mmio_rd_valid  in  1  MMIO read request valid (single cycle).
- rx_mmio_wr_valid  in  1  MMIO write request valid (single cycle).
- rx_mmio_addr  in  16  request address in 32-bit-word units.
- rx_mmio_len  in  2  0=4B, 1=8B; 2/3 treated as 8B.
- rx_mmio_tid  in  9  read transaction id.
- rx_mmio_data  in  64  write data.
- tx_mmio_rsp_valid  out  1  read response valid (single cycle, no backpressure).
- tx_mmio_rsp_tid  out  9  tid echoed from the request.
- tx_mmio_rsp_data  out  64  read data.
- csr_scratch  out  64  current scratch value, for AFU logic.

Behaviour:
- Register map (word address / byte offset):
  - 0x0/0x00 DFH, constant: [63:60]=4'h1, [59:41]=0, [40]=1 (EOL), [39:16]=0, [15:12]=DFH_VERSION, [11:0]=DFH_FEATURE_ID.
  - 0x2/0x08 AFU_ID_L = AFU_ID[63:0].
  - 0x4/0x10 AFU_ID_H = AFU_ID[127:64].
  - 0x6 and 0x8: reserved, read 0.
  - 0xA/0x28 SCRATCH, read/write.
  - 0xC/0x30 CYCLE, read-only 64-bit free-running counter.
  - 0xE/0x38 WR_COUNT, 64-bit count of accepted writes; any write to it clears it to 0.
  - Every other address reads 0; writes to them are ignored (but still counted).
- Decode:
  - 8B access uses addr[15:1]; addr[0] is ignored.
  - 4B read: selected 64-bit register's dword addr[0] is placed in both rsp_data[31:0] and [63:32].
  - 4B write to SCRATCH: updates only dword addr[0].
  - 4B write to other writable targets: treated as a full access.
- Read latency is exactly 2 cycles:
  - Request valid at edge T -> request captured into stage 1.
  - Register data selected and registered at T+1.
  - tx_mmio_rsp_valid=1 with tid and data during the cycle after edge T+2.
  - Fully pipelined: back-to-back reads each cycle give back-to-back responses, in order.
- Data snapshots:
  - CYCLE value returned is its value at edge T+1.
  - WR_COUNT value returned reflects writes taken at edge T and earlier.
- Writes take effect at the capturing edge T:
  - SCRATCH is visible to a read requested at T+1.
  - WR_COUNT increments by 1 per accepted write; wraps 2^64-1 -> 0.
  - A write to WR_COUNT clears it to 0; no increment that cycle.
- CYCLE increments every cycle when not in reset; wraps at 2^64.
- Simultaneous rd_valid and wr_valid in one cycle: both are serviced. The read sees pre-write state of the written register.
- Reset (synchronous, any cycle):
  - tx_mmio_rsp_valid=0, tid=0, data=0.
  - Pipeline flushed; in-flight reads produce no response.
  - SCRATCH=0, CYCLE=0, WR_COUNT=0, csr_scratch=0.
  - Requests presented in the reset cycle are dropped.
- No state machine beyond the 2-stage valid pipeline; no stall input exists.

Test Plan:
- Reset, then 8B read addr 0x0 tid 9'h05 with DFH_FEATURE_ID=12'h123, DFH_VERSION=1 -> two cycles later rsp_valid=1, tid=5, data=64'h1000_0100_0000_1123.
- AFU_ID=128'h0123456789ABCDEF_FEDCBA9876543210:
  - Read 0x2 -> 64'hFEDCBA9876543210.
  - Read 0x4 -> 64'h0123456789ABCDEF.
  - 4B read at 0x3 -> 64'hFEDCBA98_FEDCBA98.
- Scratch access:
  - 8B write 0xA = 64'hDEAD_BEEF_CAFE_F00D, then 4B write 0xB = 32'h1234_5678.
  - Read 0xA -> 64'h1234_5678_CAFE_F00D.
  - csr_scratch matches the read value.
- Reads at 0xA in consecutive cycles, tids 1,2,3, with a write of 64'h1 on the cycle of tid 2 -> tid1=old, tid2=old, tid3=64'h1; three consecutive response cycles.
- WR_COUNT:
  - 3 writes to 0x20 (unmapped), then read 0xE -> 3.
  - Write 0xE, then read 0xE -> 0.
  - Two CYCLE reads 10 cycles apart -> difference exactly 10.
- Read issued, reset asserted on the following cycle -> no rsp_valid ever appears for that tid; all registers read 0 after reset (CYCLE = cycles since reset release).

Source files
------------

// File: rtl/ccip_mmio_csr.sv
// ccip_mmio_csr: CCI-P MMIO register responder (DFH, AFU ID, scratch, cycle and write counters)
module ccip_mmio_csr #(
  parameter logic [127:0] AFU_ID = 128'h0,
  parameter logic [11:0] DFH_FEATURE_ID = 12'h000,
  parameter logic [3:0] DFH_VERSION = 4'h0
) (
  input  logic        pClk,
  input  logic        pck_cp2af_softReset,
  input  logic        rx_mmio_rd_valid,
  input  logic        rx_mmio_wr_valid,
  input  logic [15:0] rx_mmio_addr,
  input  logic [1:0]  rx_mmio_len,
  input  logic [8:0]  rx_mmio_tid,
  input  logic [63:0] rx_mmio_data,
  output logic        tx_mmio_rsp_valid,
  output logic [8:0]  tx_mmio_rsp_tid,
  output logic [63:0] tx_mmio_rsp_data,
  output logic [63:0] csr_scratch
);
  localparam logic [63:0] DFH = {4'h1, 19'h0, 1'b1, 24'h0, DFH_VERSION, DFH_FEATURE_ID};
  logic [63:0] scratch, cycleCnt, wrCount, scratchNext;
  logic [63:0] s1Scratch, regSel, rdData, s2Data;
  logic [31:0] rdDword;
  logic [15:0] s1Addr;
  logic [14:0] wrQword;
  logic [8:0]  s1Tid, s2Tid;
  logic        s1Valid, s1Half, s2Valid, wrHalf;
  assign wrQword = rx_mmio_addr[15:1];
  assign wrHalf = rx_mmio_len == 2'd0;
  assign csr_scratch = scratch;
  // Scratch write merge: a 4B write replaces only the addressed dword, taken from data[31:0]
  always_comb begin
    scratchNext = !wrHalf ? rx_mmio_data :
                  rx_mmio_addr[0] ? {rx_mmio_data[31:0], scratch[31:0]} : {scratch[63:32], rx_mmio_data[31:0]};
  end
  // Register state: writes land on the capturing edge; every accepted write bumps the counter unless it targets it
  always_ff @(posedge pClk) begin
    if (pck_cp2af_softReset) begin
      scratch <= '0;
      cycleCnt <= '0;
      wrCount <= '0;
    end else begin
      cycleCnt <= cycleCnt + 64'd1;
      if (rx_mmio_wr_valid && wrQword == 15'h5) scratch <= scratchNext;
      if (rx_mmio_wr_valid) wrCount <= (wrQword == 15'h7) ? '0 : wrCount + 64'd1;
    end
  end
  // Stage 1: capture the read request; scratch is snapshotted here so a same-cycle write is not seen
  always_ff @(posedge pClk) begin
    if (pck_cp2af_softReset) begin
      s1Valid <= 1'b0;
      s1Tid <= '0;
      s1Addr <= '0;
      s1Half <= 1'b0;
      s1Scratch <= '0;
    end else begin
      s1Valid <= rx_mmio_rd_valid;
      s1Tid <= rx_mmio_tid;
      s1Addr <= rx_mmio_addr;
      s1Half <= wrHalf;
      s1Scratch <= scratch;
    end
  end
  // Register map decode on the 64-bit qword index
  always_comb begin
    case (s1Addr[15:1])
      15'h0: regSel = DFH;
      15'h1: regSel = AFU_ID[63:0];
      15'h2: regSel = AFU_ID[127:64];
      15'h5: regSel = s1Scratch;
      15'h6: regSel = cycleCnt;
      15'h7: regSel = wrCount;
      default: regSel = '0;
    endcase
    rdDword = s1Addr[0] ? regSel[63:32] : regSel[31:0];
    rdData = s1Half ? {rdDword, rdDword} : regSel;
  end
  // Stage 2 selects the data, then the output stage drives the Tx response
  always_ff @(posedge pClk) begin
    if (pck_cp2af_softReset) begin
      s2Valid <= 1'b0;
      s2Tid <= '0;
      s2Data <= '0;
      tx_mmio_rsp_valid <= 1'b0;
      tx_mmio_rsp_tid <= '0;
      tx_mmio_rsp_data <= '0;
    end else begin
      s2Valid <= s1Valid;
      s2Tid <= s1Tid;
      s2Data <= rdData;
      tx_mmio_rsp_valid <= s2Valid;
      tx_mmio_rsp_tid <= s2Tid;
      tx_mmio_rsp_data <= s2Data;
    end
  end
endmodule

// File: tb/tb_ccip_mmio_csr.sv
// tb_ccip_mmio_csr: scoreboard bench for the MMIO CSR responder against a register-map reference model
module tb_ccip_mmio_csr;
  localparam logic [127:0] AFU_ID = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [63:0] DFH_EXP = 64'h1000_0100_0000_1123;
  logic pClk = 1'b0;
  logic rst, rdValid, wrValid;
  logic [15:0] addr;
  logic [1:0] len;
  logic [8:0] tid;
  logic [63:0] wdata;
  logic rspValid;
  logic [8:0] rspTid;
  logic [63:0] rspData, scratchOut;
  typedef struct {
    int due;
    logic [8:0] tid;
    logic [63:0] data;
    string name;
  } exp_t;
  exp_t expQ[$];
  int compared = 0;
  int mismatched = 0;
  int edgeCnt = 0;
  logic [63:0] mScratch, mCount, mCycle;

  always #5 pClk = ~pClk;
  always @(posedge pClk) edgeCnt++;

  ccip_mmio_csr #(.AFU_ID(AFU_ID), .DFH_FEATURE_ID(12'h123), .DFH_VERSION(4'h1)) dut (
    .pClk(pClk),
    .pck_cp2af_softReset(rst),
    .rx_mmio_rd_valid(rdValid),
    .rx_mmio_wr_valid(wrValid),
    .rx_mmio_addr(addr),
    .rx_mmio_len(len),
    .rx_mmio_tid(tid),
    .rx_mmio_data(wdata),
    .tx_mmio_rsp_valid(rspValid),
    .tx_mmio_rsp_tid(rspTid),
    .tx_mmio_rsp_data(rspData),
    .csr_scratch(scratchOut)
  );

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Reference read: register map by byte offset, then 4B dword replication
  function automatic logic [63:0] refRead(logic [15:0] a, bit half, logic [63:0] sc, logic [63:0] cy, logic [63:0] wc);
    logic [63:0] q;
    int byteOff;
    byteOff = int'(a >> 1) * 8;
    case (byteOff)
      'h00: q = DFH_EXP;
      'h08: q = AFU_ID[63:0];
      'h10: q = AFU_ID[127:64];
      'h28: q = sc;
      'h30: q = cy;
      'h38: q = wc;
      default: q = 64'h0;
    endcase
    if (half) q = a[0] ? {q[63:32], q[63:32]} : {q[31:0], q[31:0]};
    return q;
  endfunction

  // One clock: drive at negedge, update model for the coming edge, queue any read response
  task automatic tick(bit r = 0, bit rd = 0, bit wr = 0, logic [15:0] a = 0, logic [1:0] l = 0,
                      logic [8:0] t = 0, logic [63:0] d = 0, string name = "rd");
    logic [63:0] preScratch;
    rst = r; rdValid = rd; wrValid = wr; addr = a; len = l; tid = t; wdata = d;
    if (r) begin
      mScratch = 0; mCount = 0; mCycle = 0;
    end else begin
      preScratch = mScratch;
      if (wr) begin
        if ((a >> 1) == 16'h5)
          mScratch = (l != 0) ? d : a[0] ? {d[31:0], mScratch[31:0]} : {mScratch[63:32], d[31:0]};
        mCount = ((a >> 1) == 16'h7) ? 64'h0 : mCount + 64'h1;
      end
      mCycle = mCycle + 64'h1;
      if (rd) expQ.push_back('{edgeCnt + 3, t, refRead(a, l == 0, preScratch, mCycle, mCount), name});
    end
    @(posedge pClk);
    if (r) expQ.delete();
    @(negedge pClk);
  endtask

  // Monitor: flag overdue responses, then match any presented response against the queue head
  always @(negedge pClk) begin
    while (expQ.size() > 0 && expQ[0].due < edgeCnt) begin
      check({expQ[0].name, " missing rsp (due edge)"}, 64'(edgeCnt), 64'(expQ[0].due));
      void'(expQ.pop_front());
    end
    if (rspValid === 1'b1) begin
      if (expQ.size() == 0) check("spurious rsp_valid", 64'(rspValid), 64'h0);
      else begin
        exp_t e;
        e = expQ.pop_front();
        check({e.name, " timing"}, 64'(edgeCnt), 64'(e.due));
        check({e.name, " tid"}, 64'(rspTid), 64'(e.tid));
        check({e.name, " data"}, rspData, e.data);
      end
    end
  end

  initial begin
    logic [15:0] ra;
    logic [1:0] rl;
    logic [63:0] rd64;
    bit doRd, doWr;
    tick(1);
    tick(1);
    check("reset rsp_valid", 64'(rspValid), 64'h0);
    check("reset rsp_tid", 64'(rspTid), 64'h0);
    check("reset rsp_data", rspData, 64'h0);
    check("reset csr_scratch", scratchOut, 64'h0);
    tick(0, 1, 0, 16'h0, 2'd1, 9'h05, 0, "dfh");
    tick(0, 1, 0, 16'h2, 2'd1, 9'h06, 0, "afu_id_l");
    tick(0, 1, 0, 16'h4, 2'd1, 9'h07, 0, "afu_id_h");
    tick(0, 1, 0, 16'h3, 2'd0, 9'h08, 0, "afu_id_l 4B hi");
    tick(0, 0, 1, 16'hA, 2'd1, 0, 64'hDEAD_BEEF_CAFE_F00D);
    tick(0, 0, 1, 16'hB, 2'd0, 0, {2{32'h1234_5678}});
    tick(0, 1, 0, 16'hA, 2'd1, 9'h10, 0, "scratch merged");
    repeat (3) tick();
    check("csr_scratch merged", scratchOut, 64'h1234_5678_CAFE_F00D);
    tick(0, 1, 0, 16'hA, 2'd1, 9'h1, 0, "scratch tid1");
    tick(0, 1, 1, 16'hA, 2'd1, 9'h2, 64'h1, "scratch tid2");
    tick(0, 1, 0, 16'hA, 2'd1, 9'h3, 0, "scratch tid3");
    tick(0, 0, 1, 16'hE, 2'd1);
    repeat (3) tick(0, 0, 1, 16'h20, 2'd1, 0, 64'h55);
    tick(0, 1, 0, 16'hE, 2'd1, 9'h20, 0, "wr_count 3");
    tick(0, 0, 1, 16'hE, 2'd1);
    tick(0, 1, 0, 16'hE, 2'd1, 9'h21, 0, "wr_count cleared");
    tick(0, 1, 0, 16'hC, 2'd1, 9'h30, 0, "cycle A");
    repeat (9) tick();
    tick(0, 1, 0, 16'hC, 2'd1, 9'h31, 0, "cycle B");
    repeat (3) tick();
    tick(0, 1, 0, 16'hA, 2'd1, 9'h1AB, 0, "flushed");
    tick(1);
    repeat (4) tick();
    tick(0, 1, 0, 16'hA, 2'd1, 9'h40, 0, "post-reset scratch");
    tick(0, 1, 0, 16'hE, 2'd1, 9'h41, 0, "post-reset wr_count");
    tick(0, 1, 0, 16'hC, 2'd1, 9'h42, 0, "post-reset cycle");
    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16));
      rl = 2'($urandom_range(0, 3));
      doRd = $urandom_range(0, 1) == 1;
      doWr = $urandom_range(0, 2) == 0;
      if (doRd && (ra >> 1) == 16'h7) doWr = 0;
      rd64 = (rl == 0) ? {2{$urandom}} : {$urandom, $urandom};
      tick($urandom_range(0, 99) == 0, doRd, doWr, ra, rl, 9'($urandom), rd64, "random");
    end
    repeat (5) tick();
    check("scoreboard drained", 64'(expQ.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
